vertex_transform_buffer: RTL and testbench

Storage and responder for the vertex transform buffer read by the primitive assembler. Accepts transformed NDC vertices from the vertex transform stage through a valid/ready stream and writes them sequentially. Computes a per-vertex clip "invalid" flag at write time. Serves 1-cycle-latency reads of {x,y,z,invalid} on the assembler's address/read-enable port.

---
 rtl/vertex_buffer_pkg.sv | 31 +++
 rtl/vertex_ram.sv | 30 +++
 rtl/vertex_transform_buffer.sv | 142 ++++++++++++++
 tb/tb_vertex_transform_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vertex_buffer_pkg: shared types for the vertex transform buffer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vertex_buffer_pkg;

  localparam int VB_DATAWIDTH     = 24;
  localparam int VB_FRACBITS      = 13;
  localparam int VB_MAX_TRIANGLES = 2048;

  function automatic int addr_w(input int max_triangles);
    return $clog2(3 * max_triangles);
  endfunction

  typedef struct packed {
    logic signed [VB_DATAWIDTH-1:0] x;
    logic signed [VB_DATAWIDTH-1:0] y;
    logic signed [VB_DATAWIDTH-1:0] z;
    logic                           invalid;
  } vertex_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } vb_state_t;

endpackage

`default_nettype wire

// File: rtl/vertex_ram.sv
// ---------------------------------------------------------------------------
// vertex_ram: simple dual-port RAM, one write port, registered read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vertex_ram #(
  parameter int DEPTH  = 6144,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 73
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset on the array or read register so the tools can map to block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/vertex_transform_buffer.sv
// ---------------------------------------------------------------------------
// vertex_transform_buffer: clip-flagged NDC vertex store for the assembler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vertex_transform_buffer
  import vertex_buffer_pkg::*;
#(
  parameter  int VERTEX_DATAWIDTH   = VB_DATAWIDTH,
  parameter  int VERTEX_FRACBITS    = VB_FRACBITS,
  parameter  int MAX_TRIANGLE_COUNT = VB_MAX_TRIANGLES,
  localparam int ADDR_W             = addr_w(MAX_TRIANGLE_COUNT)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_clear,
  input  logic [ADDR_W:0]               i_num_vertices,
  input  logic [3*VERTEX_DATAWIDTH-1:0] i_vertex,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_filled,
  output logic [ADDR_W:0]               o_count,
  input  logic [ADDR_W-1:0]             i_vertex_addr,
  input  logic                          i_vertex_read_en,
  output logic [3*VERTEX_DATAWIDTH-1:0] o_vertex,
  output logic                          o_vertex_invalid,
  output logic                          o_vertex_dv
);

  localparam int                            W         = VERTEX_DATAWIDTH;
  localparam int                            DEPTH     = 3 * MAX_TRIANGLE_COUNT;
  localparam logic [ADDR_W:0]               DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]               CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic signed [W-1:0]           ONE       = W'(1) <<< VERTEX_FRACBITS;
  localparam logic signed [W-1:0]           NEG_ONE   = -ONE;

  // The RAM word layout comes from the package struct, so widths must agree.
  if ($bits(vertex_entry_t) != 3 * W + 1) begin : g_width_check
    $error("VERTEX_DATAWIDTH does not match vertex_buffer_pkg::VB_DATAWIDTH");
  end

  vb_state_t       state, state_next;
  logic [ADDR_W:0] count, count_next;
  logic [ADDR_W:0] target, target_next;
  logic [ADDR_W:0] num_clamped;
  logic [ADDR_W:0] count_inc;
  logic [ADDR_W:0] read_count;
  logic            fire;
  logic            clip;
  logic            in_range;
  logic            rd_ok;
  logic            rd_unwritten;
  logic            rd_dv;
  logic signed [W-1:0] vx, vy, vz;
  vertex_entry_t   wr_entry;
  vertex_entry_t   rd_entry;

  assign vx = $signed(i_vertex[3*W-1 -: W]);
  assign vy = $signed(i_vertex[2*W-1 -: W]);
  assign vz = $signed(i_vertex[W-1:0]);

  // Boundary values are inside the view volume; z spans [0, ONE] only.
  assign clip = (vx > ONE) | (vx < NEG_ONE) |
                (vy > ONE) | (vy < NEG_ONE) |
                (vz < 0)   | (vz > ONE);

  assign num_clamped = (i_num_vertices > DEPTH_CNT) ? DEPTH_CNT : i_num_vertices;
  assign count_inc   = count + CNT_ONE;
  assign fire        = i_valid & (state == FILL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      count  <= '0;
      target <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      target <= target_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    target_next = target;
    o_ready     = (state == FILL);
    o_filled    = (state == DONE);
    // A clear overrides any write landing in the same cycle.
    if (i_clear) begin
      target_next = num_clamped;
      count_next  = '0;
      state_next  = (num_clamped == '0) ? DONE : FILL;
    end else if (fire) begin
      count_next = count_inc;
      if (count_inc == target) state_next = DONE;
    end
  end

  assign o_count = count;

  assign wr_entry = '{x: vx, y: vy, z: vz, invalid: clip};

  vertex_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W ($bits(vertex_entry_t))
  ) u_ram (
    .clk     (clk),
    .wr_en   (fire & ~i_clear),
    .wr_addr (count[ADDR_W-1:0]),
    .wr_data (wr_entry),
    .rd_en   (i_vertex_read_en),
    .rd_addr (i_vertex_addr),
    .rd_data (rd_entry)
  );

  // Range check uses the post-clear count; a same-cycle write is not visible.
  assign read_count = i_clear ? '0 : count;
  assign in_range   = ({1'b0, i_vertex_addr} < read_count);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_dv        <= 1'b0;
      rd_ok        <= 1'b0;
      rd_unwritten <= 1'b0;
    end else begin
      rd_dv <= i_vertex_read_en;
      if (i_vertex_read_en) begin
        rd_ok        <= in_range;
        rd_unwritten <= ~in_range;
      end
    end
  end

  assign o_vertex_dv      = rd_dv;
  assign o_vertex         = rd_ok ? {rd_entry.x, rd_entry.y, rd_entry.z} : '0;
  assign o_vertex_invalid = rd_unwritten | (rd_ok & rd_entry.invalid);

endmodule

`default_nettype wire

// File: tb/tb_vertex_transform_buffer.sv
// ---------------------------------------------------------------------------
// tb_vertex_transform_buffer: randomized bench with a behavioural model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vertex_transform_buffer;

  localparam int W     = 24;
  localparam int AW    = 13;
  localparam int DEPTH = 6144;
  localparam int ONE   = 8192;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clear = 1'b0;
  logic [AW:0]     num = '0;
  logic [3*W-1:0]  vtx = '0;
  logic            valid = 1'b0;
  logic            ready;
  logic            filled;
  logic [AW:0]     cnt;
  logic [AW-1:0]   addr = '0;
  logic            read_en = 1'b0;
  logic [3*W-1:0]  vout;
  logic            vinv;
  logic            vdv;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = idle, 1 = filling, 2 = filled.
  int   m_mode, m_count, m_target;
  int   mx [DEPTH];
  int   my [DEPTH];
  int   mz [DEPTH];
  bit   minv [DEPTH];
  int   cur_x, cur_y, cur_z;
  bit   e_dv, e_inv;
  logic [3*W-1:0] e_vtx;

  vertex_transform_buffer dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_clear          (clear),
    .i_num_vertices   (num),
    .i_vertex         (vtx),
    .i_valid          (valid),
    .o_ready          (ready),
    .o_filled         (filled),
    .o_count          (cnt),
    .i_vertex_addr    (addr),
    .i_vertex_read_en (read_en),
    .o_vertex         (vout),
    .o_vertex_invalid (vinv),
    .o_vertex_dv      (vdv)
  );

  always #5 clk = ~clk;

  function automatic logic [3*W-1:0] pack(input int x, input int y, input int z);
    return {24'(x), 24'(y), 24'(z)};
  endfunction

  function automatic bit clipped(input int x, input int y, input int z);
    return (x > ONE) || (x < -ONE) || (y > ONE) || (y < -ONE) || (z < 0) || (z > ONE);
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return -ONE - 1;
      1: return -ONE;
      2: return -1;
      3: return 0;
      4: return ONE;
      5: return ONE + 1;
      default: return int'($urandom_range(0, 6 * ONE)) - 3 * ONE;
    endcase
  endfunction

  task automatic set_vertex(input int x, input int y, input int z);
    cur_x = x; cur_y = y; cur_z = z;
    vtx = pack(x, y, z);
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_target = 0;
    e_dv = 1'b0; e_inv = 1'b0; e_vtx = '0;
  endtask

  // Apply current inputs for one clock edge and advance the model alongside.
  task automatic cycle();
    int eff;
    if (read_en) begin
      eff  = clear ? 0 : m_count;
      e_dv = 1'b1;
      if (int'(addr) < eff) begin
        e_vtx = pack(mx[addr], my[addr], mz[addr]);
        e_inv = minv[addr];
      end else begin
        e_vtx = '0;
        e_inv = 1'b1;
      end
    end else begin
      e_dv = 1'b0;
    end
    if (clear) begin
      m_target = (int'(num) > DEPTH) ? DEPTH : int'(num);
      m_count  = 0;
      m_mode   = (m_target == 0) ? 2 : 1;
    end else if (valid && m_mode == 1) begin
      mx[m_count]   = cur_x;
      my[m_count]   = cur_y;
      mz[m_count]   = cur_z;
      minv[m_count] = clipped(cur_x, cur_y, cur_z);
      m_count++;
      if (m_count == m_target) m_mode = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    #2;
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (filled !== 1'b0) begin failures++; $display("FAIL reset_filled: got %b want 0", filled); end
    checks++; if (cnt !== '0)      begin failures++; $display("FAIL reset_count: got %0d want 0", cnt); end
    checks++; if (vdv !== 1'b0)    begin failures++; $display("FAIL reset_dv: got %b want 0", vdv); end
    checks++; if (vout !== '0)     begin failures++; $display("FAIL reset_vertex: got %h want 0", vout); end
    checks++; if (vinv !== 1'b0)   begin failures++; $display("FAIL reset_invalid: got %b want 0", vinv); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    addr = '0; read_en = 1'b1;
    cycle();
    read_en = 1'b0;
    checks++; if (vdv !== 1'b1)    begin failures++; $display("FAIL idle_read_dv: got %b want 1", vdv); end
    checks++; if (vinv !== 1'b1)   begin failures++; $display("FAIL idle_read_invalid: got %b want 1", vinv); end
    checks++; if (vout !== '0)     begin failures++; $display("FAIL idle_read_data: got %h want 0", vout); end
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL idle_ready: got %b want 0", ready); end
    cycle();
    checks++; if (vdv !== 1'b0)    begin failures++; $display("FAIL idle_dv_drop: got %b want 0", vdv); end
  endtask

  task automatic test_basic_fill();
    num = 14'd3; clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready: got %b want 1", ready); end
    valid = 1'b1;
    set_vertex(0, 0, 0);         cycle();
    set_vertex(ONE, -ONE, ONE);  cycle();
    checks++; if (filled !== 1'b0) begin failures++; $display("FAIL fill_early: got %b want 0", filled); end
    set_vertex(ONE + 1, 0, 0);   cycle();
    valid = 1'b0;
    checks++; if (filled !== 1'b1) begin failures++; $display("FAIL fill_filled: got %b want 1", filled); end
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL fill_ready_off: got %b want 0", ready); end
    checks++; if (cnt !== 14'd3)   begin failures++; $display("FAIL fill_count: got %0d want 3", cnt); end
    read_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = AW'(i);
      cycle();
      checks++; if (vdv !== 1'b1)       begin failures++; $display("FAIL fill_rd_dv[%0d]: got %b want 1", i, vdv); end
      checks++; if (vinv !== (i == 2))  begin failures++; $display("FAIL fill_rd_inv[%0d]: got %b want %b", i, vinv, (i == 2)); end
      checks++; if (vout !== e_vtx)     begin failures++; $display("FAIL fill_rd_data[%0d]: got %h want %h", i, vout, e_vtx); end
    end
    read_en = 1'b0;
  endtask

  task automatic test_hold_valid();
    num = 14'd2; clear = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b1;
    repeat (4) begin
      set_vertex(pick(), pick(), pick());
      cycle();
    end
    valid = 1'b0;
    checks++; if (cnt !== 14'd2)   begin failures++; $display("FAIL hold_count: got %0d want 2", cnt); end
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL hold_ready: got %b want 0", ready); end
    checks++; if (filled !== 1'b1) begin failures++; $display("FAIL hold_filled: got %b want 1", filled); end
  endtask

  task automatic test_same_cycle_rw();
    num = 14'd8; clear = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b1;
    repeat (3) begin
      set_vertex(pick(), pick(), pick());
      cycle();
    end
    set_vertex(100, -200, 300);
    read_en = 1'b1; addr = 13'd3;
    cycle();
    valid = 1'b0;
    checks++; if (vinv !== 1'b1) begin failures++; $display("FAIL rw_same_inv: got %b want 1", vinv); end
    checks++; if (vout !== '0)   begin failures++; $display("FAIL rw_same_data: got %h want 0", vout); end
    cycle();
    read_en = 1'b0;
    checks++; if (vinv !== 1'b0) begin failures++; $display("FAIL rw_next_inv: got %b want 0", vinv); end
    checks++; if (vout !== pack(100, -200, 300)) begin failures++; $display("FAIL rw_next_data: got %h want %h", vout, pack(100, -200, 300)); end
  endtask

  task automatic test_clear_with_write();
    num = 14'd10; clear = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b1;
    repeat (5) begin
      set_vertex(pick(), pick(), pick());
      cycle();
    end
    checks++; if (cnt !== 14'd5) begin failures++; $display("FAIL cw_pre_count: got %0d want 5", cnt); end
    clear = 1'b1; read_en = 1'b1; addr = '0;
    set_vertex(1, 2, 3);
    cycle();
    clear = 1'b0; valid = 1'b0;
    checks++; if (cnt !== '0)    begin failures++; $display("FAIL cw_count: got %0d want 0", cnt); end
    checks++; if (vinv !== 1'b1) begin failures++; $display("FAIL cw_rd_inv: got %b want 1", vinv); end
    checks++; if (vout !== '0)   begin failures++; $display("FAIL cw_rd_data: got %h want 0", vout); end
    cycle();
    read_en = 1'b0;
    checks++; if (vinv !== 1'b1) begin failures++; $display("FAIL cw_dropped_inv: got %b want 1", vinv); end
  endtask

  task automatic test_clamp();
    num = 14'd16000; clear = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_vertex(pick(), pick(), pick());
      cycle();
    end
    valid = 1'b0;
    checks++; if (filled !== 1'b1)         begin failures++; $display("FAIL clamp_filled: got %b want 1", filled); end
    checks++; if (cnt !== 14'(DEPTH))      begin failures++; $display("FAIL clamp_count: got %0d want %0d", cnt, DEPTH); end
    checks++; if (ready !== 1'b0)          begin failures++; $display("FAIL clamp_ready: got %b want 0", ready); end
    read_en = 1'b1; addr = 13'(DEPTH - 1);
    cycle();
    read_en = 1'b0;
    checks++; if (vout !== e_vtx || vinv !== e_inv) begin failures++; $display("FAIL clamp_last_read: got %h/%b want %h/%b", vout, vinv, e_vtx, e_inv); end
  endtask

  task automatic test_zero_and_reset();
    num = '0; clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++; if (filled !== 1'b1) begin failures++; $display("FAIL zero_filled: got %b want 1", filled); end
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL zero_ready: got %b want 0", ready); end
    num = 14'd6; clear = 1'b1;
    cycle();
    clear = 1'b0; valid = 1'b1;
    repeat (2) begin
      set_vertex(pick(), pick(), pick());
      cycle();
    end
    read_en = 1'b1; addr = '0;
    cycle();
    valid = 1'b0; read_en = 1'b0;
    checks++; if (vdv !== 1'b1) begin failures++; $display("FAIL midfill_dv: got %b want 1", vdv); end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (ready !== 1'b0)  begin failures++; $display("FAIL async_ready: got %b want 0", ready); end
    checks++; if (filled !== 1'b0) begin failures++; $display("FAIL async_filled: got %b want 0", filled); end
    checks++; if (cnt !== '0)      begin failures++; $display("FAIL async_count: got %0d want 0", cnt); end
    checks++; if (vdv !== 1'b0)    begin failures++; $display("FAIL async_dv: got %b want 0", vdv); end
    checks++; if (vout !== '0)     begin failures++; $display("FAIL async_vertex: got %h want 0", vout); end
    checks++; if (vinv !== 1'b0)   begin failures++; $display("FAIL async_invalid: got %b want 0", vinv); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear   = ($urandom_range(0, 39) == 0);
      num     = 14'($urandom_range(0, 20));
      valid   = ($urandom_range(0, 3) != 0);
      read_en = ($urandom_range(0, 1) == 1);
      addr    = 13'($urandom_range(0, 24));
      set_vertex(pick(), pick(), pick());
      cycle();
      checks++; if (ready !== (m_mode == 1))  begin failures++; $display("FAIL rnd_ready@%0d: got %b want %b", n, ready, (m_mode == 1)); end
      checks++; if (filled !== (m_mode == 2)) begin failures++; $display("FAIL rnd_filled@%0d: got %b want %b", n, filled, (m_mode == 2)); end
      checks++; if (cnt !== 14'(m_count))     begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, cnt, m_count); end
      checks++; if (vdv !== e_dv)             begin failures++; $display("FAIL rnd_dv@%0d: got %b want %b", n, vdv, e_dv); end
      checks++; if (vout !== e_vtx)           begin failures++; $display("FAIL rnd_vertex@%0d: got %h want %h", n, vout, e_vtx); end
      checks++; if (vinv !== e_inv)           begin failures++; $display("FAIL rnd_invalid@%0d: got %b want %b", n, vinv, e_inv); end
    end
    clear = 1'b0; valid = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    set_vertex(0, 0, 0);
    test_reset();
    test_basic_fill();
    test_hold_valid();
    test_same_cycle_rw();
    test_clear_with_write();
    test_clamp();
    test_zero_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
